// File: rtl/dcache_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_controller_if
//  Description : Bundles the three buses around the L1 data-cache controller:
//                CPU request/response, dcache_sram access and the 256-bit
//                line-wide memory port.
//                master : the controller (consumes CPU, drives SRAM/memory)
//                slave  : the surroundings (CPU, SRAM, memory)
//  Revision    : 1.0  initial release
// ============================================================================
interface dcache_controller_if #(
    parameter int ADDR_W   = 32,
    parameter int INDEX_W  = 4,
    parameter int OFFSET_W = 5,
    parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
);
    localparam int LINE_W = 8 * (1 << OFFSET_W);

    // CPU side
    logic                cpu_req_i;
    logic                cpu_wr_i;
    logic [ADDR_W-1:0]   cpu_addr_i;
    logic [31:0]         cpu_data_i;
    logic [31:0]         cpu_data_o;
    logic                cpu_stall_o;

    // dcache_sram side
    logic [INDEX_W-1:0]  sram_addr_o;
    logic [TAG_W+1:0]    sram_tag_o;
    logic [LINE_W-1:0]   sram_data_o;
    logic                sram_enable_o;
    logic                sram_write_o;
    logic [TAG_W+1:0]    sram_tag_i;
    logic [LINE_W-1:0]   sram_data_i;
    logic                sram_hit_i;

    // Memory side
    logic                mem_enable_o;
    logic                mem_write_o;
    logic [ADDR_W-1:0]   mem_addr_o;
    logic [LINE_W-1:0]   mem_data_o;
    logic [LINE_W-1:0]   mem_data_i;
    logic                mem_ack_i;

    modport master (
        input  cpu_req_i, cpu_wr_i, cpu_addr_i, cpu_data_i,
        output cpu_data_o, cpu_stall_o,
        output sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
        input  sram_tag_i, sram_data_i, sram_hit_i,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        input  mem_data_i, mem_ack_i
    );

    modport slave (
        output cpu_req_i, cpu_wr_i, cpu_addr_i, cpu_data_i,
        input  cpu_data_o, cpu_stall_o,
        input  sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
        output sram_tag_i, sram_data_i, sram_hit_i,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        output mem_data_i, mem_ack_i
    );
endinterface
`default_nettype wire

// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_controller
//  Description : L1 data-cache controller for a 2-way, 16-set, 32-byte-line
//                write-back / write-allocate cache. Serves hits with zero
//                latency and runs the miss sequence (optional dirty-victim
//                write-back, then line refill) over a 256-bit memory port.
//  Ports       : clk_i  - clock, rising edge
//                rst_i  - asynchronous, active-low reset
//                bus    - dcache_controller_if.master (CPU, SRAM, memory)
//  Revision    : 1.0  initial release
// ============================================================================
module dcache_controller #(
    parameter int ADDR_W   = 32,
    parameter int INDEX_W  = 4,
    parameter int OFFSET_W = 5,
    parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
    input  wire logic           clk_i,
    input  wire logic           rst_i,
    dcache_controller_if.master bus
);
    localparam int LINE_W = 8 * (1 << OFFSET_W);
    localparam int LSB_W  = OFFSET_W + 3;        // bit-position width within a line

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        MISS        = 3'd1,
        WRITEBACK   = 3'd2,
        REFILL      = 3'd3,
        REFILL_DONE = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]   mem_data_q, mem_data_d;

    // Address split
    logic [TAG_W-1:0]    w_tag;
    logic [INDEX_W-1:0]  w_index;
    logic [OFFSET_W-3:0] w_word;
    logic [LSB_W-1:0]    w_word_lsb;
    logic [ADDR_W-1:0]   w_line_addr;
    logic                unused_byte_bits;

    assign w_tag            = bus.cpu_addr_i[ADDR_W-1:INDEX_W+OFFSET_W];
    assign w_index          = bus.cpu_addr_i[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign w_word           = bus.cpu_addr_i[OFFSET_W-1:2];
    assign w_word_lsb       = {w_word, 5'b00000};
    assign w_line_addr      = {w_tag, w_index, {OFFSET_W{1'b0}}};
    assign unused_byte_bits = ^bus.cpu_addr_i[1:0];

    // Combinational results before reset gating
    logic                w_stall;
    logic                w_sram_en;
    logic                w_sram_wr;
    logic [LINE_W-1:0]   w_sram_data;
    logic [TAG_W+1:0]    w_sram_tag;
    logic                w_mem_en;
    logic                w_mem_wr;
    logic [LINE_W-1:0]   w_merged;
    logic [31:0]         w_rd_word;

    // Store-hit line: resident line with the addressed word replaced
    always_comb begin
        w_merged                   = bus.sram_data_i;
        w_merged[w_word_lsb +: 32] = bus.cpu_data_i;
    end

    assign w_rd_word = bus.sram_data_i[w_word_lsb +: 32];

    // State and memory-side address/data registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        w_stall     = 1'b1;
        w_sram_en   = 1'b0;
        w_sram_wr   = 1'b0;
        w_sram_data = '0;
        w_sram_tag  = {2'b10, w_tag};
        w_mem_en    = 1'b0;
        w_mem_wr    = 1'b0;

        case (state_q)
            IDLE: begin
                w_stall   = bus.cpu_req_i & ~bus.sram_hit_i;
                w_sram_en = bus.cpu_req_i;
                if (bus.cpu_req_i) begin
                    if (bus.sram_hit_i) begin
                        if (bus.cpu_wr_i) begin
                            w_sram_wr   = 1'b1;
                            w_sram_data = w_merged;
                            w_sram_tag  = {2'b11, w_tag};
                        end
                    end else begin
                        state_d = MISS;
                    end
                end
            end

            // SRAM is presenting the LRU victim this cycle
            MISS: begin
                if (bus.sram_tag_i[TAG_W+1] && bus.sram_tag_i[TAG_W]) begin
                    mem_addr_d = {bus.sram_tag_i[TAG_W-1:0], w_index, {OFFSET_W{1'b0}}};
                    mem_data_d = bus.sram_data_i;
                    state_d    = WRITEBACK;
                end else begin
                    mem_addr_d = w_line_addr;
                    state_d    = REFILL;
                end
            end

            WRITEBACK: begin
                w_mem_en = 1'b1;
                w_mem_wr = 1'b1;
                if (bus.mem_ack_i) begin
                    mem_addr_d = w_line_addr;
                    state_d    = REFILL;
                end
            end

            // Refill data is only valid during the ack cycle, so it goes
            // straight into the SRAM instead of through a register.
            REFILL: begin
                w_mem_en = 1'b1;
                if (bus.mem_ack_i) begin
                    w_sram_en   = 1'b1;
                    w_sram_wr   = 1'b1;
                    w_sram_data = bus.mem_data_i;
                    w_sram_tag  = {2'b10, w_tag};
                    state_d     = REFILL_DONE;
                end
            end

            // One settling cycle; the held request then hits in IDLE
            REFILL_DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // While reset is held every output reads zero, including the
    // combinational stall and load-data paths.
    assign bus.cpu_stall_o   = rst_i & w_stall;
    assign bus.cpu_data_o    = rst_i ? w_rd_word : '0;
    assign bus.sram_addr_o   = rst_i ? w_index : '0;
    assign bus.sram_tag_o    = rst_i ? w_sram_tag : '0;
    assign bus.sram_data_o   = rst_i ? w_sram_data : '0;
    assign bus.sram_enable_o = rst_i & w_sram_en;
    assign bus.sram_write_o  = rst_i & w_sram_wr;
    assign bus.mem_enable_o  = rst_i & w_mem_en;
    assign bus.mem_write_o   = rst_i & w_mem_wr;
    assign bus.mem_addr_o    = mem_addr_q;
    assign bus.mem_data_o    = mem_data_q;
endmodule
`default_nettype wire

// File: tb/tb_dcache_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_dcache_controller
//  Description : Self-checking bench for dcache_controller with behavioural
//                2-way SRAM and line memory around it, a word-level golden
//                memory and an MRU-ordered cache-occupancy model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dcache_controller;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dcache_controller_if bus ();

    dcache_controller dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // ---------------- golden word memory ----------------
    function automatic logic [31:0] init_word(input logic [29:0] wa);
        return {wa, 2'b00} ^ 32'hC3A5_F00F;
    endfunction

    function automatic logic [255:0] init_line(input logic [26:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word({la, 3'(w)});
        return l;
    endfunction

    logic [31:0]  gold [logic [29:0]];
    logic [255:0] mem  [logic [26:0]];

    function automatic logic [31:0] gold_rd(input logic [31:0] a);
        return gold.exists(a[31:2]) ? gold[a[31:2]] : init_word(a[31:2]);
    endfunction

    function automatic logic [255:0] gold_line(input logic [26:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = gold_rd({la, 3'(w), 2'b00});
        return l;
    endfunction

    function automatic logic [255:0] mem_line(input logic [26:0] la);
        return mem.exists(la) ? mem[la] : init_line(la);
    endfunction

    // ---------------- cache occupancy model (MRU first) ----------------
    typedef struct packed { logic [22:0] tag; logic dirty; } rline_t;
    rline_t rset [16][$];
    int lat = 4;

    task automatic model_access(input bit wr, input logic [31:0] a,
                                output int stalls, output int acks, output logic [31:0] wb_addr);
        int     pos;
        rline_t e, v;
        logic [3:0] idx;
        idx = a[8:5];
        pos = -1;
        wb_addr = '0;
        for (int i = 0; i < rset[idx].size(); i++)
            if (rset[idx][i].tag == a[31:9]) pos = i;
        if (pos >= 0) begin
            e = rset[idx][pos];
            rset[idx].delete(pos);
            stalls = 0;
            acks   = 0;
        end else begin
            e.tag = a[31:9];
            e.dirty = 1'b0;
            stalls = lat + 3;
            acks   = 1;
            if (rset[idx].size() == 2) begin
                v = rset[idx].pop_back();
                if (v.dirty) begin
                    stalls  = 2 * lat + 3;
                    acks    = 2;
                    wb_addr = {v.tag, idx, 5'b0};
                end
            end
        end
        if (wr) e.dirty = 1'b1;
        rset[idx].push_front(e);
    endtask

    // ---------------- behavioural 2-way SRAM ----------------
    logic [24:0]  s_tag  [16][2] = '{default: '0};
    logic [255:0] s_data [16][2] = '{default: '0};
    logic         s_lru  [16]    = '{default: 1'b0};
    logic [3:0]   e_idx;
    logic         e_hit, e_way, ew_way;

    always_comb begin
        e_idx = bus.cpu_addr_i[8:5];
        e_hit = 1'b0;
        e_way = s_lru[e_idx];
        for (int w = 0; w < 2; w++)
            if (s_tag[e_idx][w][24] && s_tag[e_idx][w][22:0] == bus.cpu_addr_i[31:9]) begin
                e_hit = 1'b1;
                e_way = w[0];
            end
        bus.sram_hit_i  = e_hit;
        bus.sram_tag_i  = s_tag[e_idx][e_way];
        bus.sram_data_i = s_data[e_idx][e_way];
    end

    always_comb begin
        ew_way = s_lru[bus.sram_addr_o];
        for (int w = 0; w < 2; w++)
            if (s_tag[bus.sram_addr_o][w][24] &&
                s_tag[bus.sram_addr_o][w][22:0] == bus.sram_tag_o[22:0])
                ew_way = w[0];
    end

    always @(posedge clk) begin
        if (bus.sram_enable_o) begin
            if (bus.sram_write_o) begin
                s_tag[bus.sram_addr_o][ew_way]  <= bus.sram_tag_o;
                s_data[bus.sram_addr_o][ew_way] <= bus.sram_data_o;
                s_lru[bus.sram_addr_o]          <= ~ew_way;
            end else if (bus.sram_hit_i) begin
                s_lru[e_idx] <= ~e_way;
            end
        end
    end

    // ---------------- memory responder ----------------
    int          cnt = 0;
    int          ack_cnt = 0;
    int          pulse_req = 0;
    int          pulse_done = 0;
    logic [31:0] exp_wb_addr = '0;
    logic [31:0] exp_rf_addr = '0;

    initial begin
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack_i = 1'b0;
            if (!rst_n) begin
                cnt = 0;
            end else if (pulse_req != pulse_done) begin
                pulse_done++;
                bus.mem_ack_i = 1'b1;
            end else if (bus.mem_enable_o) begin
                cnt++;
                if (cnt >= lat) begin
                    cnt = 0;
                    ack_cnt++;
                    bus.mem_ack_i = 1'b1;
                    if (bus.mem_write_o) begin
                        chk("wb_addr", 256'(bus.mem_addr_o), 256'(exp_wb_addr));
                        chk("wb_data", bus.mem_data_o, gold_line(exp_wb_addr[31:5]));
                        mem[bus.mem_addr_o[31:5]] = bus.mem_data_o;
                    end else begin
                        chk("refill_addr", 256'(bus.mem_addr_o), 256'(exp_rf_addr));
                        bus.mem_data_i = mem_line(bus.mem_addr_o[31:5]);
                        #1;
                        chk("refill_sram_write", 256'(bus.sram_write_o & bus.sram_enable_o), 256'(1));
                        chk("refill_sram_tag", 256'(bus.sram_tag_o), 256'({2'b10, exp_rf_addr[31:9]}));
                        chk("refill_sram_data", bus.sram_data_o, bus.mem_data_i);
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // ---------------- CPU access (starts and ends at a negedge) ----------------
    task automatic do_access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                             input int lt, input int t_stalls, input int t_acks);
        int m_st, m_ak, st, a0;
        logic [31:0]  wb;
        logic [255:0] exp_line;
        lat = lt;
        model_access(wr, a, m_st, m_ak, wb);
        if (t_stalls >= 0) begin
            m_st = t_stalls;
            m_ak = t_acks;
        end
        exp_wb_addr = wb;
        exp_rf_addr = {a[31:5], 5'b0};
        a0 = ack_cnt;
        bus.cpu_req_i  = 1'b1;
        bus.cpu_wr_i   = wr;
        bus.cpu_addr_i = a;
        bus.cpu_data_i = d;
        #1;
        chk("sram_addr", 256'(bus.sram_addr_o), 256'(a[8:5]));
        st = 0;
        while (bus.cpu_stall_o && st < 200) begin
            @(negedge clk);
            #1;
            st++;
        end
        chk("stall_cycles", 256'(st), 256'(m_st));
        if (st < 200) begin
            if (!wr) begin
                chk("load_data", 256'(bus.cpu_data_o), 256'(gold_rd(a)));
                chk("load_no_write", 256'(bus.sram_write_o), 256'(0));
            end else begin
                exp_line = gold_line(a[31:5]);
                exp_line[a[4:2]*32 +: 32] = d;
                chk("store_write", 256'(bus.sram_write_o), 256'(1));
                chk("store_tag", 256'(bus.sram_tag_o), 256'({2'b11, a[31:9]}));
                chk("store_line", bus.sram_data_o, exp_line);
            end
        end
        @(posedge clk);
        if (wr) gold[a[31:2]] = d;
        @(negedge clk);
        chk("mem_acks", 256'(ack_cnt - a0), 256'(m_ak));
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          lt;
        int          stalls;
        int          acks;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int     rt, ri, rw;
        logic [31:0] ra;

        // set 9 (addr bits 8:5 = 9); tag = addr >> 9
        vecs[0] = '{1'b0, 32'h0000_0124, 32'h0,         4, 7, 1}; // cold load, clean
        vecs[1] = '{1'b0, 32'h0000_0120, 32'h0,         4, 0, 0}; // load hit
        vecs[2] = '{1'b1, 32'h0000_013C, 32'hDEADBEEF,  4, 0, 0}; // store hit word 7
        vecs[3] = '{1'b0, 32'h0000_0324, 32'h0,         3, 6, 1}; // 2nd way, empty victim
        vecs[4] = '{1'b0, 32'h0000_0524, 32'h0,         2, 7, 2}; // dirty tag0 victim
        vecs[5] = '{1'b0, 32'h0000_013C, 32'h0,         1, 4, 1}; // re-read stored word
        vecs[6] = '{1'b1, 32'h0000_0528, 32'h1234_5678, 1, 0, 0}; // store hit tag2
        vecs[7] = '{1'b0, 32'h0000_0724, 32'h0,         3, 6, 1}; // clean tag0 victim
        vecs[8] = '{1'b0, 32'h0000_0924, 32'h0,         2, 7, 2}; // dirty tag2 victim

        // Reset: outputs zero even with a missing request presented
        bus.cpu_req_i  = 1'b1;
        bus.cpu_wr_i   = 1'b0;
        bus.cpu_addr_i = 32'h0000_0124;
        bus.cpu_data_i = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall",     256'(bus.cpu_stall_o),   256'(0));
        chk("rst_cpu_data",  256'(bus.cpu_data_o),    256'(0));
        chk("rst_sram_en",   256'(bus.sram_enable_o), 256'(0));
        chk("rst_sram_wr",   256'(bus.sram_write_o),  256'(0));
        chk("rst_sram_tag",  256'(bus.sram_tag_o),    256'(0));
        chk("rst_sram_addr", 256'(bus.sram_addr_o),   256'(0));
        chk("rst_sram_data", bus.sram_data_o,         256'(0));
        chk("rst_mem_en",    256'(bus.mem_enable_o),  256'(0));
        chk("rst_mem_wr",    256'(bus.mem_write_o),   256'(0));
        chk("rst_mem_addr",  256'(bus.mem_addr_o),    256'(0));
        chk("rst_mem_data",  bus.mem_data_o,          256'(0));
        @(negedge clk);
        bus.cpu_req_i = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++)
            do_access(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].lt,
                      vecs[i].stalls, vecs[i].acks);

        // mem_ack_i pulsed while idle with a resident-line load held
        bus.cpu_req_i  = 1'b1;
        bus.cpu_wr_i   = 1'b0;
        bus.cpu_addr_i = 32'h0000_0724;
        @(posedge clk);
        pulse_req++;
        @(negedge clk);
        #1;
        chk("idle_ack_no_write", 256'(bus.sram_write_o), 256'(0));
        chk("idle_ack_stall",    256'(bus.cpu_stall_o),  256'(0));
        chk("idle_ack_data",     256'(bus.cpu_data_o),   256'(gold_rd(32'h0000_0724)));
        @(negedge clk);
        #1;
        chk("idle_ack_after_stall",  256'(bus.cpu_stall_o),  256'(0));
        chk("idle_ack_after_mem_en", 256'(bus.mem_enable_o), 256'(0));
        begin
            int s0, k0;
            logic [31:0] w0;
            model_access(1'b0, 32'h0000_0724, s0, k0, w0);
        end
        @(negedge clk);

        // Reset asserted in the middle of a refill
        lat = 10;
        exp_rf_addr = 32'h0000_0E60;
        bus.cpu_req_i  = 1'b1;
        bus.cpu_wr_i   = 1'b0;
        bus.cpu_addr_i = 32'h0000_0E64;
        repeat (4) @(negedge clk);
        #1;
        chk("pre_rst_refill_en",   256'(bus.mem_enable_o), 256'(1));
        chk("pre_rst_refill_wr",   256'(bus.mem_write_o),  256'(0));
        chk("pre_rst_refill_addr", 256'(bus.mem_addr_o),   256'(32'h0000_0E60));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_en",   256'(bus.mem_enable_o), 256'(0));
        chk("mid_rst_stall",    256'(bus.cpu_stall_o),  256'(0));
        chk("mid_rst_sram_wr",  256'(bus.sram_write_o), 256'(0));
        chk("mid_rst_mem_addr", 256'(bus.mem_addr_o),   256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        do_access(1'b0, 32'h0000_0E64, 32'h0, 3, -1, -1);

        // Randomised traffic over two sets with four competing tags
        for (int n = 0; n < 250; n++) begin
            rt = $urandom_range(0, 3);
            ri = $urandom_range(0, 1);
            rw = $urandom_range(0, 7);
            ra = {23'(rt), 4'(ri), 3'(rw), 2'($urandom_range(0, 3))};
            do_access(1'($urandom_range(0, 1)), ra, $urandom, $urandom_range(1, 5), -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
